// File: rtl/bus_rx_fifo.sv
// Receive-side FIFO behind the bus master: registered write acknowledge, first-word fall-through consumer port.
// Optional BUS_RX_FIFO_DROP_CNT_EN adds a saturating count of writes refused while full.
module bus_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic             rd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
`ifdef BUS_RX_FIFO_DROP_CNT_EN
  output logic [7:0]       drop_cnt,
`endif
  output logic             overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_q, rd_d;
  logic             wr_req, push, pop, refused;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign rd        = rd_q;
  assign out_valid = !empty;
  // Gate the unreset memory so out_data reads 0 whenever nothing is queued.
  assign out_data  = empty ? '0 : mem_q[rptr_q];

  // Full is judged on registered state, so a same-cycle pop never frees room for a push.
  assign wr_req  = wr && en;
  assign push    = wr_req && !full;
  assign refused = wr_req && full;
  assign pop     = out_ready && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rd_d    = push;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rd_q    <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rd_q    <= rd_d;
    end
  end

`ifdef BUS_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (refused && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
  assign overflow = (drop_cnt_q != 8'd0);
`else
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q | refused;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_bus_rx_fifo.sv
// Bench for bus_rx_fifo: queue-based reference model checked every cycle, plus directed literal checks.
module tb_bus_rx_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] data_in = 'x;
  logic             out_ready = 1'b0;
  logic             rd;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;
`ifdef BUS_RX_FIFO_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  bus_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .en(en), .data_in(data_in),
    .rd(rd), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty),
`ifdef BUS_RX_FIFO_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus the acknowledge and overflow bookkeeping.
  logic [WIDTH-1:0] mq[$];
  logic             m_rd = 1'b0;
  logic             m_ovf = 1'b0;
  int               m_drops = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_rd    = 1'b0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      automatic bit wreq   = (wr === 1'b1) && (en === 1'b1);
      automatic bit can_wr = wreq && (mq.size() < DEPTH);
      automatic bit can_rd = (out_ready === 1'b1) && (mq.size() > 0);
      if (can_rd) void'(mq.pop_front());
      if (can_wr) mq.push_back(data_in);
      if (wreq && !can_wr) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
      m_rd = can_wr;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cyc_rd", 32'(rd), 32'(m_rd));
    chk("cyc_count", 32'(count), 32'(mq.size()));
    chk("cyc_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("cyc_empty", 32'(empty), 32'(mq.size() == 0));
    chk("cyc_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("cyc_ovf", 32'(overflow), 32'(m_ovf));
`ifdef BUS_RX_FIFO_DROP_CNT_EN
    chk("cyc_drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
    if (mq.size() != 0) chk("cyc_data", 32'(out_data), 32'(mq[0]));
  end

  task automatic push_word(input logic [WIDTH-1:0] d);
    @(negedge clk);
    wr = 1'b1; en = 1'b1; data_in = d;
  endtask

  task automatic idle();
    @(negedge clk);
    wr = 1'b0; en = 1'b0; data_in = 'x; out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rd", 32'(rd), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;

    // Three back-to-back writes with the consumer stalled.
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    idle();
    chk("w3_rd", 32'(rd), 32'h1);
    chk("w3_count", 32'(count), 32'd3);
    chk("w3_data", 32'(out_data), 32'h11);
    chk("w3_valid", 32'(out_valid), 32'h1);
    @(negedge clk);
    chk("w3_rd_low", 32'(rd), 32'h0);

    // Drain in order.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("drain_data", 32'(out_data), 32'((i + 1) * 8'h11));
      out_ready = 1'b1;
    end
    idle();
    chk("drain_empty", 32'(empty), 32'h1);
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_count", 32'(count), 32'h0);

    // Fill 0..7, then a ninth write that must be refused.
    for (int i = 0; i < 8; i++) push_word(8'(i));
    push_word(8'hAA);
    idle();
    chk("ovf_full", 32'(full), 32'h1);
    chk("ovf_rd", 32'(rd), 32'h0);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_count", 32'(count), 32'd8);
`ifdef BUS_RX_FIFO_DROP_CNT_EN
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    // Full: push and pop together; the pop wins, the push is refused.
    chk("fp_head", 32'(out_data), 32'h00);
    push_word(8'h55);
    out_ready = 1'b1;
    idle();
    chk("fp_count", 32'(count), 32'd7);
    chk("fp_ovf", 32'(overflow), 32'h1);
    chk("fp_head2", 32'(out_data), 32'h01);
`ifdef BUS_RX_FIFO_DROP_CNT_EN
    chk("fp_drop_cnt", 32'(drop_cnt), 32'd2);
`endif

    // Drain the rest: 1..7, with 0xAA and 0x55 absent.
    for (int i = 1; i < 8; i++) begin
      if (i > 1) @(negedge clk);
      chk("fill_drain", 32'(out_data), 32'(i));
      out_ready = 1'b1;
    end
    idle();
    chk("fill_empty", 32'(empty), 32'h1);

    // Hold occupancy at 4 with simultaneous push/pop across two pointer wraps.
    for (int i = 0; i < 4; i++) push_word(8'h40 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      push_word(8'h77 + 8'(i));
      out_ready = 1'b1;
      if (i > 0) chk("steady_count", 32'(count), 32'd4);
    end
    idle();
    chk("steady_final", 32'(count), 32'd4);
    chk("steady_head", 32'(out_data), 32'h77 + 32'd16);

    // Reach 5 entries, then reset asynchronously between edges.
    push_word(8'hC0);
    idle();
    chk("pre_rst_count", 32'(count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_full", 32'(full), 32'h0);
    chk("arst_ovf", 32'(overflow), 32'h0);
    chk("arst_data", 32'(out_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    push_word(8'h99);
    idle();
    chk("post_rst_data", 32'(out_data), 32'h99);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_rd", 32'(rd), 32'h1);

    // A consumer ready while empty must not disturb anything.
    @(negedge clk); out_ready = 1'b1;
    idle();
    idle(); out_ready = 1'b1;
    idle();
    chk("end_empty", 32'(empty), 32'h1);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_rx_fifo.md
Name: bus_rx_fifo

Overview:
- Receive-side buffer placed directly downstream of the bus master.
- Captures each write the master drives on the wr/en/data_in signals and returns a one-cycle rd acknowledge.
- Queues the words in a FIFO and hands them to a local consumer over a valid/ready port.
- Decouples the master's write rate from the consumer's drain rate.

Parameters:
- WIDTH, 8, data word width in bits; matches the bus width.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  single system clock; all state changes on posedge.
- rst_n  input  1  reset, asynchronous assert, active low.
- wr  input  1  write strobe from bus master.
- en  input  1  bus enable from bus master; a write requires wr && en.
- data_in  input  WIDTH  write data from bus master.
- rd  output  1  write acknowledge to master; pulses for one cycle per accepted word.
- out_data  output  WIDTH  head-of-FIFO word to consumer.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; set when a write is attempted while full.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - Deassertion of rst_n is taken synchronously to clk by the integrating level.
- Reset values:
  - rd=0, out_valid=0, count=0, full=0, empty=1, overflow=0.
  - Read and write pointers cleared to 0.
  - out_data=0.
  - Memory contents are not reset.
- Push:
  - Occurs at a posedge when wr && en && !full.
  - data_in is written to mem[wptr] and wptr advances.
  - rd is asserted for exactly the following cycle (registered; latency 1).
- Push while full:
  - Word is dropped and pointers are unchanged.
  - rd stays 0.
  - overflow is set and held until reset.
- Back-to-back writes: rd pulses on each cycle following an accepted push, so continuous accepts give continuous rd high.
- Output (first-word fall-through):
  - out_data = mem[rptr]; out_valid = !empty.
  - A word pushed at edge N is visible on out_valid/out_data after edge N (a 1-cycle write-to-read latency).
- Pop:
  - Occurs at a posedge when out_valid && out_ready; rptr advances.
  - out_ready while empty has no effect.
  - out_data must remain stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - When full, push is still refused: full has priority and is evaluated before the pop in the same cycle.
  - When empty, only the push takes effect.
- Pointers:
  - Width $clog2(DEPTH).
  - Wrap modulo DEPTH; no gap or bubble at wrap-around.
  - count is tracked explicitly or derived from extended pointers; it must never exceed DEPTH or underflow.
- Status timing: full and empty are registered or derived from registered state only, with no combinational path from wr/en/out_ready.
- Reset mid-operation: asserting rst_n low discards all queued words immediately and forces the reset values asynchronously.
- X-safety: X on data_in while wr && en is low must not propagate to any status output.

Optional Feature:
- Macro: BUS_RX_FIFO_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt, 8 bits, reset to 0.
  - Increments on every write refused because the FIFO is full.
  - Saturates at 255.
  - overflow = (drop_cnt != 0).
- When undefined:
  - No drop_cnt port and no counter logic.
  - overflow is a plain sticky flag.

Test Plan:
- Reset, then 3 writes 0x11, 0x22, 0x33 on consecutive cycles with out_ready=0 -> rd high 3 consecutive cycles; count=3; out_data=0x11; out_valid=1.
- Then out_ready=1 for 3 cycles with no writes -> consumer sees 0x11, 0x22, 0x33 in order; then empty=1, out_valid=0, count=0.
- DEPTH=8: write 0..7, then attempt a 9th write 0xAA -> full=1, rd=0 on the 9th, overflow=1; drain returns 0..7 with 0xAA absent. With the macro defined, drop_cnt=1.
- Fill to 8, then assert write of 0x55 and out_ready together -> pop of 0x00 occurs, push refused, count=7, overflow=1.
- Count at 4: push 0x77 and pop on the same edge, repeated 20 cycles -> count stays 4; pointers wrap twice; data order preserved.
- Count at 5: pull rst_n low mid-cycle -> outputs reach reset values before the next edge; after release, the first write 0x99 appears at out_data with count=1.
